// File: rtl/lsu_fault_report_if.sv
// ============================================================================
// Module      : lsu_fault_report_if
// Description : dc1 fault flags, pipe controls and TLU error packet bundle
//               for lsu_fault_report.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface lsu_fault_report_if #(
    parameter int CNT_W = 16
);
    logic              lsu_valid_dc1;
    logic              lsu_store_dc1;
    logic [31:0]       start_addr_dc1;
    logic              access_fault_dc1;
    logic              misaligned_fault_dc1;
    logic              lsu_freeze_dc3;
    logic              flush_dc2;
    logic              flush_dc3;
    logic              tlu_err_ack;
    logic              fault_cnt_clr;
    logic              lsu_error_valid;
    logic              lsu_error_exc_type;
    logic              lsu_error_store;
    logic [31:0]       lsu_error_addr;
    logic              lsu_fault_dropped;
    logic [CNT_W-1:0]  lsu_fault_cnt;

    modport master (
        output lsu_valid_dc1, lsu_store_dc1, start_addr_dc1,
               access_fault_dc1, misaligned_fault_dc1,
               lsu_freeze_dc3, flush_dc2, flush_dc3,
               tlu_err_ack, fault_cnt_clr,
        input  lsu_error_valid, lsu_error_exc_type, lsu_error_store,
               lsu_error_addr, lsu_fault_dropped, lsu_fault_cnt
    );

    modport slave (
        input  lsu_valid_dc1, lsu_store_dc1, start_addr_dc1,
               access_fault_dc1, misaligned_fault_dc1,
               lsu_freeze_dc3, flush_dc2, flush_dc3,
               tlu_err_ack, fault_cnt_clr,
        output lsu_error_valid, lsu_error_exc_type, lsu_error_store,
               lsu_error_addr, lsu_fault_dropped, lsu_fault_cnt
    );
endinterface

`default_nettype wire

// File: rtl/lsu_fault_report.sv
// ============================================================================
// Module      : lsu_fault_report
// Description : Carries dc1 address-check faults down to dc3 and holds the
//               first surviving fault as an error packet until TLU ack.
//               Optional saturating fault counter: RV_LSU_FAULT_CNT_EN.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module lsu_fault_report #(
    parameter int CNT_W         = 16,
    parameter bit MISALIGN_PRIO = 1'b1
) (
    input  logic              clk,
    input  logic              rst_l,
    lsu_fault_report_if.slave bus
);

    typedef struct packed {
        logic        valid;
        logic        store;
        logic        acc;
        logic        mis;
        logic [31:0] addr;
    } pipe_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    pipe_t       w_dc1;
    pipe_t       w_dc2_nxt;
    pipe_t       w_dc3_nxt;
    pipe_t       r_dc2;
    pipe_t       r_dc3;

    state_t      r_state;
    logic        r_err_valid;
    logic        r_err_exc;
    logic        r_err_store;
    logic [31:0] r_err_addr;
    logic        r_dropped;

    logic        w_cap;
    logic        w_load;
    logic        w_exc;

    always_comb begin
        w_dc1       = '0;
        w_dc1.valid = bus.lsu_valid_dc1;
        w_dc1.store = bus.lsu_store_dc1;
        w_dc1.acc   = bus.lsu_valid_dc1 & bus.access_fault_dc1;
        w_dc1.mis   = bus.lsu_valid_dc1 & bus.misaligned_fault_dc1;
        w_dc1.addr  = bus.start_addr_dc1;
    end

    // Flushes are applied after the advance/hold choice so they win over both.
    always_comb begin
        w_dc2_nxt = r_dc2;
        w_dc3_nxt = r_dc3;
        if (!bus.lsu_freeze_dc3) begin
            w_dc2_nxt       = w_dc1;
            w_dc3_nxt       = r_dc2;
            w_dc3_nxt.valid = r_dc2.valid & ~bus.flush_dc2;
        end
        if (bus.flush_dc2) begin
            w_dc2_nxt.valid = 1'b0;
        end
        if (bus.flush_dc3) begin
            w_dc3_nxt.valid = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_dc2 <= '0;
            r_dc3 <= '0;
        end else begin
            r_dc2 <= w_dc2_nxt;
            r_dc3 <= w_dc3_nxt;
        end
    end

    // A frozen dc3 entry cannot capture; it captures once on its release cycle.
    assign w_cap  = r_dc3.valid & (r_dc3.acc | r_dc3.mis)
                  & ~bus.lsu_freeze_dc3 & ~bus.flush_dc3;
    assign w_load = w_cap & ((r_state == ST_IDLE) | bus.tlu_err_ack);
    assign w_exc  = (r_dc3.acc & r_dc3.mis) ? MISALIGN_PRIO : r_dc3.mis;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_state     <= ST_IDLE;
            r_err_valid <= 1'b0;
            r_err_exc   <= 1'b0;
            r_err_store <= 1'b0;
            r_err_addr  <= '0;
            r_dropped   <= 1'b0;
        end else begin
            r_dropped <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_cap) begin
                        r_state     <= ST_PEND;
                        r_err_valid <= 1'b1;
                    end
                end
                ST_PEND: begin
                    if (bus.tlu_err_ack && !w_cap) begin
                        r_state     <= ST_IDLE;
                        r_err_valid <= 1'b0;
                    end else if (!bus.tlu_err_ack && w_cap) begin
                        r_dropped   <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_err_valid <= 1'b0;
                end
            endcase
            // Packet fields only change on a load; they keep their value after ack.
            if (w_load) begin
                r_err_exc   <= w_exc;
                r_err_store <= r_dc3.store;
                r_err_addr  <= r_dc3.addr;
            end
        end
    end

    assign bus.lsu_error_valid    = r_err_valid;
    assign bus.lsu_error_exc_type = r_err_exc;
    assign bus.lsu_error_store    = r_err_store;
    assign bus.lsu_error_addr     = r_err_addr;
    assign bus.lsu_fault_dropped  = r_dropped;

`ifdef RV_LSU_FAULT_CNT_EN
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_cnt <= '0;
        end else if (bus.fault_cnt_clr) begin
            r_cnt <= '0;
        end else if (w_load && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign bus.lsu_fault_cnt = r_cnt;
`else
    logic w_unused_cnt_clr;

    assign w_unused_cnt_clr  = bus.fault_cnt_clr;
    assign bus.lsu_fault_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lsu_fault_report.sv
// ============================================================================
// Module      : tb_lsu_fault_report
// Description : Directed plus random check of lsu_fault_report against a
//               cycle-level behavioural model (both MISALIGN_PRIO settings).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lsu_fault_report;

    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk;
    logic rst_l;

    logic        d_valid, d_store, d_acc, d_mis;
    logic [31:0] d_addr;
    logic        d_freeze, d_fl2, d_fl3, d_ack, d_clr;

    int total;
    int bad;

    lsu_fault_report_if #(.CNT_W(CNT_W)) bus1 ();
    lsu_fault_report_if #(.CNT_W(CNT_W)) bus0 ();

    assign bus1.lsu_valid_dc1        = d_valid;
    assign bus1.lsu_store_dc1        = d_store;
    assign bus1.start_addr_dc1       = d_addr;
    assign bus1.access_fault_dc1     = d_acc;
    assign bus1.misaligned_fault_dc1 = d_mis;
    assign bus1.lsu_freeze_dc3       = d_freeze;
    assign bus1.flush_dc2            = d_fl2;
    assign bus1.flush_dc3            = d_fl3;
    assign bus1.tlu_err_ack          = d_ack;
    assign bus1.fault_cnt_clr        = d_clr;

    assign bus0.lsu_valid_dc1        = d_valid;
    assign bus0.lsu_store_dc1        = d_store;
    assign bus0.start_addr_dc1       = d_addr;
    assign bus0.access_fault_dc1     = d_acc;
    assign bus0.misaligned_fault_dc1 = d_mis;
    assign bus0.lsu_freeze_dc3       = d_freeze;
    assign bus0.flush_dc2            = d_fl2;
    assign bus0.flush_dc3            = d_fl3;
    assign bus0.tlu_err_ack          = d_ack;
    assign bus0.fault_cnt_clr        = d_clr;

    lsu_fault_report #(.CNT_W(CNT_W), .MISALIGN_PRIO(1'b1)) dut1 (
        .clk   (clk),
        .rst_l (rst_l),
        .bus   (bus1.slave)
    );

    lsu_fault_report #(.CNT_W(CNT_W), .MISALIGN_PRIO(1'b0)) dut0 (
        .clk   (clk),
        .rst_l (rst_l),
        .bus   (bus0.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: an op record per pipe slot plus the held packet.
    typedef struct {
        bit          live;
        bit          store;
        bit          acc;
        bit          mis;
        logic [31:0] addr;
    } op_t;

    op_t         m_slot[2];
    bit          m_pend, m_store, m_exc1, m_exc0, m_drop;
    logic [31:0] m_addr;
    int          m_cnt;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) m_slot[i] = '{0, 0, 0, 0, 32'h0};
        m_pend = 0; m_store = 0; m_exc1 = 0; m_exc0 = 0; m_drop = 0;
        m_addr = 32'h0; m_cnt = 0;
    endtask

    task automatic model_advance();
        op_t incoming;
        op_t old2, old3;
        bit  faulty, taken;
        old2 = m_slot[0];
        old3 = m_slot[1];
        incoming = '{d_valid, d_store, d_valid && d_acc, d_valid && d_mis, d_addr};
        faulty = old3.live && (old3.acc || old3.mis) && !d_freeze && !d_fl3;
        taken  = faulty && (!m_pend || d_ack);
        m_drop = faulty && m_pend && !d_ack;
        if (taken) begin
            m_pend  = 1;
            m_store = old3.store;
            m_addr  = old3.addr;
            m_exc1  = old3.mis;
            m_exc0  = old3.mis && !old3.acc;
`ifdef RV_LSU_FAULT_CNT_EN
            if (m_cnt < CMAX) m_cnt = m_cnt + 1;
`endif
        end else if (m_pend && d_ack) begin
            m_pend = 0;
        end
`ifdef RV_LSU_FAULT_CNT_EN
        if (d_clr) m_cnt = 0;
`endif
        if (!d_freeze) begin
            m_slot[1] = old2;
            if (d_fl2) m_slot[1].live = 0;
            m_slot[0] = incoming;
        end
        if (d_fl2) m_slot[0].live = 0;
        if (d_fl3) m_slot[1].live = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("valid_p1",   {31'b0, bus1.lsu_error_valid},    {31'b0, m_pend});
        chk("exc_p1",     {31'b0, bus1.lsu_error_exc_type}, {31'b0, m_exc1});
        chk("store_p1",   {31'b0, bus1.lsu_error_store},    {31'b0, m_store});
        chk("addr_p1",    bus1.lsu_error_addr,              m_addr);
        chk("dropped_p1", {31'b0, bus1.lsu_fault_dropped},  {31'b0, m_drop});
        chk("cnt_p1",     {28'b0, bus1.lsu_fault_cnt},      m_cnt);
        chk("valid_p0",   {31'b0, bus0.lsu_error_valid},    {31'b0, m_pend});
        chk("exc_p0",     {31'b0, bus0.lsu_error_exc_type}, {31'b0, m_exc0});
        chk("addr_p0",    bus0.lsu_error_addr,              m_addr);
        chk("cnt_p0",     {28'b0, bus0.lsu_fault_cnt},      m_cnt);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_advance();
        check_all();
    endtask

    task automatic drive(input bit v, input bit st, input logic [31:0] a, input bit acc, input bit mis);
        d_valid = v; d_store = st; d_addr = a; d_acc = acc; d_mis = mis;
    endtask

    task automatic quiet();
        drive(0, 0, 32'h0, 0, 0);
        d_freeze = 0; d_fl2 = 0; d_fl3 = 0; d_ack = 0; d_clr = 0;
    endtask

    task automatic async_reset();
        #3;
        rst_l = 1'b0;
        #1;
        model_reset();
        chk("rst_now_valid", {31'b0, bus1.lsu_error_valid}, 32'h0);
        chk("rst_now_addr",  bus1.lsu_error_addr,           32'h0);
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst_l = 1'b1;
    endtask

    task automatic fault_to_pend(input logic [31:0] a, input bit acc, input bit mis);
        drive(1, 0, a, acc, mis);
        step();
        drive(0, 0, 32'h0, 0, 0);
        step();
        step();
    endtask

    int cnt_before;

    initial begin
        total = 0;
        bad   = 0;
        rst_l = 1'b0;
        quiet();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("reset_cnt", {28'b0, bus1.lsu_fault_cnt}, 32'h0);
        rst_l = 1'b1;
        step();

        // 1: misaligned load, 3-cycle latency, hold, clear after ack
        drive(1, 0, 32'h1000_0002, 0, 1);
        step();
        quiet();
        step();
        chk("t1_not_yet", {31'b0, bus1.lsu_error_valid}, 32'h0);
        step();
        chk("t1_valid", {31'b0, bus1.lsu_error_valid},    32'h1);
        chk("t1_exc",   {31'b0, bus1.lsu_error_exc_type}, 32'h1);
        chk("t1_store", {31'b0, bus1.lsu_error_store},    32'h0);
        chk("t1_addr",  bus1.lsu_error_addr,              32'h1000_0002);
        step();
        step();
        chk("t1_hold", {31'b0, bus1.lsu_error_valid}, 32'h1);
        d_ack = 1;
        step();
        chk("t1_acked", {31'b0, bus1.lsu_error_valid}, 32'h0);
        chk("t1_addr_kept", bus1.lsu_error_addr, 32'h1000_0002);
        d_ack = 0;

        // 2: both faults on a store, priority by parameter
        drive(1, 1, 32'h0000_4444, 1, 1);
        step();
        quiet();
        step();
        step();
        chk("t2_exc_prio1", {31'b0, bus1.lsu_error_exc_type}, 32'h1);
        chk("t2_exc_prio0", {31'b0, bus0.lsu_error_exc_type}, 32'h0);
        chk("t2_store",     {31'b0, bus1.lsu_error_store},    32'h1);
        d_ack = 1;
        step();
        d_ack = 0;

        // 3: fault frozen in dc3 for 4 cycles
        cnt_before = m_cnt;
        drive(1, 0, 32'h0000_0100, 1, 0);
        step();
        quiet();
        step();
        d_freeze = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t3_frozen", {31'b0, bus1.lsu_error_valid}, 32'h0);
        end
        d_freeze = 0;
        step();
        chk("t3_released", {31'b0, bus1.lsu_error_valid}, 32'h1);
`ifdef RV_LSU_FAULT_CNT_EN
        chk("t3_cnt", {28'b0, bus1.lsu_fault_cnt}, cnt_before + 1);
`else
        chk("t3_cnt", {28'b0, bus1.lsu_fault_cnt}, 32'h0);
`endif
        d_ack = 1;
        step();
        d_ack = 0;
        step();

        // 4: flushes kill unreported faults but never a held packet
        drive(1, 0, 32'h0000_0200, 1, 0);
        step();
        quiet();
        d_fl2 = 1;
        step();
        d_fl2 = 0;
        step();
        step();
        chk("t4_fl2_none", {31'b0, bus1.lsu_error_valid}, 32'h0);
        drive(1, 0, 32'h0000_0300, 0, 1);
        step();
        quiet();
        step();
        d_fl3 = 1;
        step();
        d_fl3 = 0;
        step();
        chk("t4_fl3_none", {31'b0, bus1.lsu_error_valid}, 32'h0);
        fault_to_pend(32'h0000_0400, 1, 0);
        d_fl2 = 1;
        d_fl3 = 1;
        step();
        quiet();
        chk("t4_pend_kept", {31'b0, bus1.lsu_error_valid}, 32'h1);
        chk("t4_pend_addr", bus1.lsu_error_addr, 32'h0000_0400);
        d_ack = 1;
        step();
        d_ack = 0;

        // 5: drop while held, then back-to-back replacement
        fault_to_pend(32'h2000_0000, 1, 0);
        drive(1, 0, 32'h3000_0001, 0, 1);
        step();
        quiet();
        step();
        step();
        chk("t5_dropped", {31'b0, bus1.lsu_fault_dropped}, 32'h1);
        chk("t5_keep_a",  bus1.lsu_error_addr, 32'h2000_0000);
        step();
        chk("t5_drop_pulse", {31'b0, bus1.lsu_fault_dropped}, 32'h0);
        drive(1, 0, 32'h3000_0001, 0, 1);
        step();
        quiet();
        step();
        d_ack = 1;
        step();
        d_ack = 0;
        chk("t5_valid_b", {31'b0, bus1.lsu_error_valid}, 32'h1);
        chk("t5_addr_b",  bus1.lsu_error_addr, 32'h3000_0001);
        chk("t5_no_drop", {31'b0, bus1.lsu_fault_dropped}, 32'h0);
        d_ack = 1;
        step();
        d_ack = 0;

        // 6: counter saturation and clear-over-increment
        d_clr = 1;
        step();
        d_clr = 0;
        d_ack = 1;
        for (int i = 0; i < 20; i++) begin
            drive(1, i[0], 32'h5000_0000 + i, 1, 0);
            step();
        end
        drive(0, 0, 32'h0, 0, 0);
        step();
        step();
        step();
`ifdef RV_LSU_FAULT_CNT_EN
        chk("t6_saturated", {28'b0, bus1.lsu_fault_cnt}, CMAX);
`else
        chk("t6_cnt_off", {28'b0, bus1.lsu_fault_cnt}, 32'h0);
`endif
        drive(1, 0, 32'h6000_0000, 0, 1);
        step();
        quiet();
        d_ack = 1;
        step();
        d_clr = 1;
        step();
        d_clr = 0;
        chk("t6_clr_wins", {28'b0, bus1.lsu_fault_cnt}, 32'h0);
        chk("t6_clr_cap",  {31'b0, bus1.lsu_error_valid}, 32'h1);
        step();
        d_ack = 0;
        fault_to_pend(32'h7000_0004, 1, 1);
        chk("t6_pend_before_rst", {31'b0, bus1.lsu_error_valid}, 32'h1);
        async_reset();
        step();

        // Random phase
        for (int n = 0; n < 2000; n++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
            d_freeze = $urandom_range(0, 5) == 0;
            d_fl2    = $urandom_range(0, 9) == 0;
            d_fl3    = $urandom_range(0, 9) == 0;
            d_ack    = $urandom_range(0, 2) == 0;
            d_clr    = $urandom_range(0, 39) == 0;
            if ($urandom_range(0, 299) == 0) begin
                async_reset();
            end else begin
                step();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
